shift_deserializer: RTL

Serial-in, parallel-out receiver that reassembles the MSB-first bit stream produced by the team's `shift_register` transmitter back into DATA_WIDTH-bit words. Bits are sampled on qualified clock edges, counted, and delivered as a parallel word. The word is held in an output buffer with a full/read handshake, and overruns are flagged. It sits at the receiving end of the single-bit link between blocks of the accumulator processor datapath.

---
 rtl/shift_deserializer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-in/parallel-out receiver for the MSB-first single-bit link.
// Latency: a word is visible on data_out the cycle after the edge that samples its final bit.
// Backpressure: one-word holding buffer (full/rd_enable); a word completing while full and unread is dropped and flags overrun.
//
// Parameters:
//   DATA_WIDTH  word width in bits (>= 2)
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   enable      bit-valid strobe; data_in sampled when enable=1 and sync=0
//   sync        realign: clears bit counter, shift buffer and overrun; no sample that cycle
//   data_in     serial bit, MSB first
//   rd_enable   consumer acknowledge of the held word
//   data_out    last delivered word
//   data_valid  one-cycle pulse per delivered word
//   full        delivered word not yet acknowledged
//   overrun     sticky: a word was dropped because the buffer was full
//   parity_err  parity result of the last delivered word (0 unless parity enabled)
// Build option:
//   SHIFT_DESERIALIZER_PARITY_EN  append an even-parity bit to each frame and check it on delivery.

module shift_deserializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sync,
  input  logic                  data_in,
  input  logic                  rd_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  overrun,
  output logic                  parity_err
);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
  localparam int FRAME = DATA_WIDTH + 1;
`else
  localparam int FRAME = DATA_WIDTH;
`endif
  localparam int CNT_W = (FRAME > 2) ? $clog2(FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  full_q, full_d;
  logic                  ovr_q, ovr_d;
  logic                  vld_q, vld_d;

  logic                  sample;
  logic                  complete;
  logic                  deliver;
  logic                  drop;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [DATA_WIDTH-1:0] assembled;

  // sync takes priority over enable: a sync cycle never samples a bit.
  assign sample    = enable & ~sync;
  assign complete  = sample & (cnt_q == LAST_CNT);
  // A read on the completion edge frees the buffer in time for the new word.
  assign deliver   = complete & (~full_q | rd_enable);
  assign drop      = complete & full_q & ~rd_enable;
  assign shift_nxt = {shift_q[DATA_WIDTH-2:0], data_in};

`ifdef SHIFT_DESERIALIZER_PARITY_EN
  // The final bit of the frame is parity, so the shift register already
  // holds exactly the data bits when the frame completes.
  assign assembled = shift_q;
`else
  // The final data bit is still on data_in; fold it in combinationally so the
  // word is delivered on the same edge that samples it.
  assign assembled = shift_nxt;
`endif

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    full_d  = full_q;
    ovr_d   = ovr_q;
    vld_d   = 1'b0;

    if (sync) begin
      shift_d = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (enable) begin
      shift_d = shift_nxt;
      cnt_d   = complete ? '0 : cnt_q + CNT_W'(1);
    end

    // Read acknowledge; a delivery on the same edge re-fills the buffer below.
    if (rd_enable && full_q) begin
      full_d = 1'b0;
    end

    if (deliver) begin
      data_d = assembled;
      full_d = 1'b1;
      vld_d  = 1'b1;
    end

    if (drop) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
      vld_q   <= vld_d;
    end
  end

`ifdef SHIFT_DESERIALIZER_PARITY_EN
  logic perr_q, perr_d;

  // Even parity: XOR over data bits and the parity bit must be 0.
  // Dropped words leave the previous result in place.
  always_comb begin
    perr_d = perr_q;
    if (deliver) begin
      perr_d = (^shift_q) ^ data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = data_q;
  assign data_valid = vld_q;
  assign full       = full_q;
  assign overrun    = ovr_q;

endmodule
